aes_encrypt_controller: RTL
===========================

# aes_encrypt_controller

Iterative AES-128 encryption engine, one round per clock. It is the transmit-side counterpart of the AES decryption controller: it produces the 128-bit ciphertext that the decryptor consumes. The round keys are expanded on the fly, so no precomputed key schedule is needed. It sits between the I/O interface, which supplies plaintext and key under the `io_ready` handshake, and any consumer of the ciphertext.

## Interface
- No parameters. The cipher is fixed at AES-128: 10 rounds, Nk = 4.
- `clk  in  1` — single clock; all state updates on the rising edge.
- `reset_n  in  1` — asynchronous, active-low reset.
- `io_ready  in  1` — start request from the I/O side; level-sensitive.
- `msg_pt  in  128` — plaintext. Byte 0 is `[127:120]`; column-major as in FIPS-197.
- `key  in  128` — cipher key, same byte order.
- `msg_en  out  128` — ciphertext. Valid only while `aes_ready` = 1.
- `aes_ready  out  1` — high while the result is held (DONE state).
- `busy  out  1` — high in ROUND and FINAL.

## Operation
- **States:** IDLE, ROUND, FINAL, DONE.
- **Registers:**
  - `aesstate[127:0]`, drives `msg_en`.
  - `rkey[127:0]`, current round key.
  - `rcon[7:0]`.
  - `round[3:0]`.
- **IDLE, `io_ready` = 1:**
  - Capture inputs: `aesstate <= msg_pt ^ key`, `rkey <= key`, `rcon <= 8'h01`, `round <= 1`.
  - Go to ROUND.
  - `msg_pt` and `key` are not sampled again until the next start.
- **IDLE, `io_ready` = 0:** hold all registers.
- **ROUND, per cycle:**
  - `nk = expand(rkey, rcon)`.
  - `aesstate <= MixColumns(ShiftRows(SubBytes(aesstate))) ^ nk`.
  - `rkey <= nk`, `rcon <= xtime(rcon)`, `round <= round + 1`.
  - If `round` == 9, go to FINAL; otherwise stay in ROUND.
- **FINAL:**
  - `aesstate <= ShiftRows(SubBytes(aesstate)) ^ expand(rkey, rcon)`, using `rcon` = 8'h36.
  - Go to DONE.
- **DONE:**
  - Hold `aesstate`; `aes_ready` = 1.
  - Return to IDLE when `io_ready` = 0 (four-phase handshake).
  - Stay in DONE while `io_ready` = 1.
- **`expand(w, rc)`:**
  - `t = SubWord(RotWord(w[31:0])) ^ {rc, 24'h0}`.
  - `w0' = w[127:96] ^ t`, `w1' = w[95:64] ^ w0'`, `w2' = w[63:32] ^ w1'`, `w3' = w[31:0] ^ w2'`.
- **`xtime(x)`:** `{x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00)`. The `rcon` sequence is 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- **S-box:** 20 instances, 16 for the state and 4 for SubWord. All are purely combinational ROM/logic; no pipeline stages inside a round.
- **Ignored inputs:** `io_ready`, `msg_pt` and `key` changes during ROUND or FINAL have no effect.
- **Outputs:** `aes_ready` and `busy` are decoded from the state register only; no combinational path from inputs.
- **Reset (any time, including mid-encryption):**
  - State → IDLE.
  - `aesstate` = 0, `rkey` = 0, `rcon` = 8'h01, `round` = 0.
  - `msg_en` = 0, `aes_ready` = 0, `busy` = 0.
  - A partial computation is discarded.

## Timing
- Start is accepted at the edge where IDLE samples `io_ready` = 1 (edge E0).
- Rounds 1–9 complete at edges E1–E9. Round 10 completes at E10.
- `aes_ready` rises in the cycle after E10. Latency is 10 clocks from the accepting edge to the first cycle `aes_ready` = 1.
- `busy` is high for exactly 10 cycles, between E0 and E10.
- `msg_en` shows intermediate state during `busy`. After return to IDLE it keeps the ciphertext until the next start.
- **Minimum start-to-start spacing:** 12 cycles.
  - 10 compute cycles.
  - At least 1 DONE cycle with `io_ready` = 0 (the transition out of DONE).
  - 1 IDLE cycle sampling `io_ready` = 1.
- **`io_ready` held high continuously:** exactly one encryption runs, then the block parks in DONE. There is no auto-restart.

## Test plan
- **FIPS-197 App. B:** `key` = 2b7e151628aed2a6abf7158809cf4f3c, `msg_pt` = 3243f6a8885a308d313198a2e0370734.
  - After E1, `aesstate` = a49c7ff2689f352b6b5bea43026a5049 and `rkey` = a0fafe1788542cb123a339392a6c7605.
  - `aes_ready` rises exactly 10 clocks after acceptance with `msg_en` = 3925841d02dc09fbdc118597196a0b32.
- **FIPS-197 C.1:** `key` = 000102030405060708090a0b0c0d0e0f, `msg_pt` = 00112233445566778899aabbccddeeff → `msg_en` = 69c4e0d86a7b0430d8cdb78070b4c55a.
- **Input corruption:** change `msg_pt` and `key` to all-ones, and toggle `io_ready`, at E3–E8 of the App. B run. Ciphertext is unchanged and latency is still 10.
- **Reset mid-run:** assert `reset_n` = 0 asynchronously between E5 and E6.
  - Immediately: `busy` = 0, `aes_ready` = 0, `msg_en` = 0.
  - After release, a fresh C.1 run produces the correct ciphertext.
- **Handshake:**
  - Hold `io_ready` = 1 for 30 cycles: one completion, `aes_ready` stays 1, no second run.
  - Drop `io_ready`: `aes_ready` = 0 on the next cycle.
  - Re-raise `io_ready` with new inputs: second result correct, start-to-start spacing ≥ 12.
- **Back-to-back:** 100 random key/plaintext pairs, each checked against a reference model, with `rcon` observed to reach 8'h36 in FINAL every run.

Source files
------------

// File: rtl/aes_encrypt_controller.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Start on io_ready in IDLE, result held in DONE until io_ready drops.
module aes_sbox (
    input  logic [7:0] x,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] pw;
    logic [7:0] inv;

    // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform
    always_comb begin
        pw  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            pw  = gmul(pw, pw);
            inv = gmul(inv, pw);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_encrypt_controller (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         io_ready,
    input  logic [127:0] msg_pt,
    input  logic [127:0] key,
    output logic [127:0] msg_en,
    output logic         aes_ready,
    output logic         busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state;
    logic [127:0] aesstate;
    logic [127:0] rkey;
    logic [7:0]   rcon;
    logic [3:0]   round;

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the block lives at [127-8i -: 8]; byte index = col*4 + row
    logic [15:0][7:0] sb_in, sb_out, sr, mc;
    logic [127:0]     sr_flat, mc_flat;

    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        assign sb_in[i] = aesstate[127-8*i -: 8];
        aes_sbox u_sbox (.x(sb_in[i]), .y(sb_out[i]));
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[c*4+r] = sb_out[((c+r)%4)*4+r];
        end
        assign mc[c*4+0] = xt(sr[c*4]) ^ xt(sr[c*4+1]) ^ sr[c*4+1] ^ sr[c*4+2] ^ sr[c*4+3];
        assign mc[c*4+1] = sr[c*4] ^ xt(sr[c*4+1]) ^ xt(sr[c*4+2]) ^ sr[c*4+2] ^ sr[c*4+3];
        assign mc[c*4+2] = sr[c*4] ^ sr[c*4+1] ^ xt(sr[c*4+2]) ^ xt(sr[c*4+3]) ^ sr[c*4+3];
        assign mc[c*4+3] = xt(sr[c*4]) ^ sr[c*4] ^ sr[c*4+1] ^ sr[c*4+2] ^ xt(sr[c*4+3]);
    end

    for (genvar i = 0; i < 16; i++) begin : g_pack
        assign sr_flat[127-8*i -: 8] = sr[i];
        assign mc_flat[127-8*i -: 8] = mc[i];
    end

    // Key expansion: SubWord(RotWord(w3)) ^ rcon, then the xor chain across words
    logic [31:0]  rot_word, sub_word, t;
    logic [127:0] nk;

    assign rot_word = {rkey[23:0], rkey[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_key_sbox
        aes_sbox u_sbox (.x(rot_word[31-8*j -: 8]), .y(sub_word[31-8*j -: 8]));
    end

    assign t            = sub_word ^ {rcon, 24'h000000};
    assign nk[127:96]   = rkey[127:96] ^ t;
    assign nk[95:64]    = rkey[95:64]  ^ nk[127:96];
    assign nk[63:32]    = rkey[63:32]  ^ nk[95:64];
    assign nk[31:0]     = rkey[31:0]   ^ nk[63:32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            aesstate <= '0;
            rkey     <= '0;
            rcon     <= 8'h01;
            round    <= 4'd0;
        end else begin
            case (state)
                IDLE: if (io_ready) begin
                    aesstate <= msg_pt ^ key;
                    rkey     <= key;
                    rcon     <= 8'h01;
                    round    <= 4'd1;
                    state    <= ROUND;
                end
                ROUND: begin
                    aesstate <= mc_flat ^ nk;
                    rkey     <= nk;
                    rcon     <= xt(rcon);
                    round    <= round + 4'd1;
                    if (round == 4'd9) state <= FINAL;
                end
                FINAL: begin
                    aesstate <= sr_flat ^ nk;
                    rkey     <= nk;
                    state    <= DONE;
                end
                default: if (!io_ready) state <= IDLE;
            endcase
        end
    end

    assign msg_en    = aesstate;
    assign aes_ready = (state == DONE);
    assign busy      = (state == ROUND) || (state == FINAL);
endmodule
